// File: rtl/ysyx_23060201_wbu.sv
// Writeback unit: retires one EXU instruction per handshake. Loads wait for
// the LSU response, which is then aligned and extended. Produces a
// registered one-cycle GPR write pulse and a one-cycle commit pulse.
module ysyx_23060201_wbu #(
    parameter int unsigned GPR_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      exu_valid,
    output logic                      exu_ready,
    input  logic [DATA_WIDTH-1:0]     exu_pc,
    input  logic [GPR_ADDR_WIDTH-1:0] exu_rd,
    input  logic                      exu_rd_wen,
    input  logic [DATA_WIDTH-1:0]     exu_result,
    input  logic                      exu_is_load,
    input  logic [2:0]                exu_load_funct3,
    input  logic [1:0]                exu_addr_lo,
    input  logic                      lsu_rvalid,
    input  logic [DATA_WIDTH-1:0]     lsu_rdata,
    output logic                      gpr_wen,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0]     gpr_wdata,
    output logic                      commit_valid,
    output logic [DATA_WIDTH-1:0]     commit_pc,
    output logic                      pend_valid,
    output logic [GPR_ADDR_WIDTH-1:0] pend_rd
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0]     ld_pc;
    logic [GPR_ADDR_WIDTH-1:0] ld_rd;
    logic                      ld_rd_wen;
    logic [2:0]                ld_funct3;
    logic [1:0]                ld_addr_lo;

    logic                      accept;
    logic                      alu_retire;
    logic                      load_accept;
    logic                      load_done;
    logic [DATA_WIDTH-1:0]     shifted;
    logic [DATA_WIDTH-1:0]     load_data;

    assign accept      = exu_valid & exu_ready;
    assign alu_retire  = accept & ~exu_is_load;
    assign load_accept = accept & exu_is_load;
    assign load_done   = (state == WAIT_LD) & lsu_rvalid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_accept) state_nxt = WAIT_LD;
            WAIT_LD: if (lsu_rvalid)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded handshake and hazard outputs
    always_comb begin
        exu_ready  = 1'b0;
        pend_valid = 1'b0;
        pend_rd    = '0;
        case (state)
            IDLE:    exu_ready = 1'b1;
            WAIT_LD: begin
                pend_valid = 1'b1;
                pend_rd    = ld_rd;
            end
            default: exu_ready = 1'b0;
        endcase
    end

    // Capture the load context on accept so EXU can move on
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_pc      <= '0;
            ld_rd      <= '0;
            ld_rd_wen  <= 1'b0;
            ld_funct3  <= '0;
            ld_addr_lo <= '0;
        end else if (load_accept) begin
            ld_pc      <= exu_pc;
            ld_rd      <= exu_rd;
            ld_rd_wen  <= exu_rd_wen;
            ld_funct3  <= exu_load_funct3;
            ld_addr_lo <= exu_addr_lo;
        end
    end

    // Align the response word and extend per load type; misaligned halves zero-fill
    always_comb begin
        shifted   = lsu_rdata >> {ld_addr_lo, 3'b000};
        load_data = shifted;
        case (ld_funct3)
            F3_LB:   load_data = {{(DATA_WIDTH-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
            F3_LH:   load_data = {{(DATA_WIDTH-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
            F3_LW:   load_data = shifted;
            F3_LBU:  load_data = {{(DATA_WIDTH-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
            F3_LHU:  load_data = {{(DATA_WIDTH-HALF_W){1'b0}}, shifted[HALF_W-1:0]};
            default: load_data = shifted;
        endcase
    end

    // Registered retire: pulses clear each cycle, payload holds between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_wen      <= 1'b0;
            gpr_waddr    <= '0;
            gpr_wdata    <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else begin
            gpr_wen      <= 1'b0;
            commit_valid <= 1'b0;
            if (load_done) begin
                gpr_wen      <= ld_rd_wen & (ld_rd != '0);
                gpr_waddr    <= ld_rd;
                gpr_wdata    <= load_data;
                commit_valid <= 1'b1;
                commit_pc    <= ld_pc;
            end else if (alu_retire) begin
                gpr_wen      <= exu_rd_wen & (exu_rd != '0);
                gpr_waddr    <= exu_rd;
                gpr_wdata    <= exu_result;
                commit_valid <= 1'b1;
                commit_pc    <= exu_pc;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060201_wbu.sv
// Directed testbench for the writeback unit. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_ysyx_23060201_wbu;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [31:0] exu_pc;
    logic [4:0]  exu_rd;
    logic        exu_rd_wen;
    logic [31:0] exu_result;
    logic        exu_is_load;
    logic [2:0]  exu_load_funct3;
    logic [1:0]  exu_addr_lo;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        pend_valid;
    logic [4:0]  pend_rd;

    int vectors;
    int miscompares;

    ysyx_23060201_wbu dut (
        .clk             (clk),
        .rst             (rst),
        .exu_valid       (exu_valid),
        .exu_ready       (exu_ready),
        .exu_pc          (exu_pc),
        .exu_rd          (exu_rd),
        .exu_rd_wen      (exu_rd_wen),
        .exu_result      (exu_result),
        .exu_is_load     (exu_is_load),
        .exu_load_funct3 (exu_load_funct3),
        .exu_addr_lo     (exu_addr_lo),
        .lsu_rvalid      (lsu_rvalid),
        .lsu_rdata       (lsu_rdata),
        .gpr_wen         (gpr_wen),
        .gpr_waddr       (gpr_waddr),
        .gpr_wdata       (gpr_wdata),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .pend_valid      (pend_valid),
        .pend_rd         (pend_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        exu_valid       = 1'b0;
        exu_pc          = 32'h0;
        exu_rd          = 5'd0;
        exu_rd_wen      = 1'b0;
        exu_result      = 32'h0;
        exu_is_load     = 1'b0;
        exu_load_funct3 = 3'b000;
        exu_addr_lo     = 2'b00;
        lsu_rvalid      = 1'b0;
        lsu_rdata       = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (exu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got=%b want=1", exu_ready);
        end
        vectors++;
        if ({gpr_wen, commit_valid, pend_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_pulses got=%b want=000", {gpr_wen, commit_valid, pend_valid});
        end
        vectors++;
        if ({gpr_waddr, gpr_wdata, commit_pc, pend_rd} !== 74'h0) begin
            miscompares++;
            $display("FAIL reset_payload waddr=%0d wdata=%h pc=%h pend_rd=%0d want all 0",
                     gpr_waddr, gpr_wdata, commit_pc, pend_rd);
        end
    endtask

    task automatic test_alu_retire();
        exu_valid  = 1'b1;
        exu_pc     = 32'h8000_0000;
        exu_rd     = 5'd5;
        exu_rd_wen = 1'b1;
        exu_result = 32'hDEAD_BEEF;
        @(negedge clk);
        drive_idle();
        vectors++;
        if ({gpr_wen, commit_valid} !== 2'b11) begin
            miscompares++;
            $display("FAIL alu_pulses got wen=%b commit=%b want 1 1", gpr_wen, commit_valid);
        end
        vectors++;
        if (gpr_waddr !== 5'd5 || gpr_wdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL alu_write got waddr=%0d wdata=%h want 5 deadbeef", gpr_waddr, gpr_wdata);
        end
        vectors++;
        if (commit_pc !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL alu_pc got=%h want=80000000", commit_pc);
        end
        @(negedge clk);
        vectors++;
        if ({gpr_wen, commit_valid} !== 2'b00 || gpr_wdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL alu_single_pulse got wen=%b commit=%b wdata=%h want 0 0 deadbeef",
                     gpr_wen, commit_valid, gpr_wdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            exu_valid  = 1'b1;
            exu_pc     = 32'h8000_0100 + 32'(4 * i);
            exu_rd     = 5'(i);
            exu_rd_wen = 1'b1;
            exu_result = 32'hA000_0000 + 32'(i);
            vectors++;
            if (exu_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d] got=%b want=1", i, exu_ready);
            end
            @(negedge clk);
            vectors++;
            if (gpr_wen !== 1'b1 || commit_valid !== 1'b1 || gpr_waddr !== 5'(i)
                || gpr_wdata !== 32'hA000_0000 + 32'(i)
                || commit_pc !== 32'h8000_0100 + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL b2b_retire[%0d] got wen=%b commit=%b waddr=%0d wdata=%h pc=%h want 1 1 %0d %h %h",
                         i, gpr_wen, commit_valid, gpr_waddr, gpr_wdata, commit_pc,
                         i, 32'hA000_0000 + 32'(i), 32'h8000_0100 + 32'(4 * i));
            end
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [1:0] lo,
                             input logic [4:0] rd, input logic [31:0] rdata,
                             input int wait_cycles, input logic [31:0] exp);
        logic [31:0] pc;
        pc              = 32'h8000_2000 + 32'({rd, 2'b00});
        exu_valid       = 1'b1;
        exu_pc          = pc;
        exu_rd          = rd;
        exu_rd_wen      = 1'b1;
        exu_result      = 32'h1357_9BDF;
        exu_is_load     = 1'b1;
        exu_load_funct3 = f3;
        exu_addr_lo     = lo;
        @(negedge clk);
        drive_idle();
        vectors++;
        if (commit_valid !== 1'b0 || gpr_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_no_early_commit got commit=%b wen=%b want 0 0", name, commit_valid, gpr_wen);
        end
        for (int w = 0; w < wait_cycles; w++) begin
            vectors++;
            if (exu_ready !== 1'b0 || pend_valid !== 1'b1 || pend_rd !== rd || commit_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_wait[%0d] got ready=%b pend=%b pend_rd=%0d commit=%b want 0 1 %0d 0",
                         name, w, exu_ready, pend_valid, pend_rd, commit_valid, rd);
            end
            @(negedge clk);
        end
        lsu_rvalid = 1'b1;
        lsu_rdata  = rdata;
        @(negedge clk);
        lsu_rvalid = 1'b0;
        lsu_rdata  = 32'h0;
        vectors++;
        if (commit_valid !== 1'b1 || commit_pc !== pc || gpr_wen !== (rd != 5'd0)) begin
            miscompares++;
            $display("FAIL %s_commit got commit=%b pc=%h wen=%b want 1 %h %b",
                     name, commit_valid, commit_pc, gpr_wen, pc, rd != 5'd0);
        end
        vectors++;
        if (gpr_waddr !== rd || gpr_wdata !== exp) begin
            miscompares++;
            $display("FAIL %s_data got waddr=%0d wdata=%h want %0d %h", name, gpr_waddr, gpr_wdata, rd, exp);
        end
        vectors++;
        if (exu_ready !== 1'b1 || pend_valid !== 1'b0 || pend_rd !== 5'd0) begin
            miscompares++;
            $display("FAIL %s_release got ready=%b pend=%b pend_rd=%0d want 1 0 0",
                     name, exu_ready, pend_valid, pend_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_x0_and_stray();
        exu_valid  = 1'b1;
        exu_pc     = 32'h8000_3000;
        exu_rd     = 5'd0;
        exu_rd_wen = 1'b1;
        exu_result = 32'h0000_0055;
        @(negedge clk);
        drive_idle();
        vectors++;
        if (commit_valid !== 1'b1 || gpr_wen !== 1'b0 || commit_pc !== 32'h8000_3000) begin
            miscompares++;
            $display("FAIL x0_write got commit=%b wen=%b pc=%h want 1 0 80003000",
                     commit_valid, gpr_wen, commit_pc);
        end
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        lsu_rvalid = 1'b0;
        lsu_rdata  = 32'h0;
        vectors++;
        if (commit_valid !== 1'b0 || gpr_wen !== 1'b0 || exu_ready !== 1'b1
            || pend_valid !== 1'b0 || gpr_wdata !== 32'h0000_0055) begin
            miscompares++;
            $display("FAIL stray_rvalid got commit=%b wen=%b ready=%b pend=%b wdata=%h want 0 0 1 0 00000055",
                     commit_valid, gpr_wen, exu_ready, pend_valid, gpr_wdata);
        end
    endtask

    task automatic test_reset_mid_load();
        exu_valid       = 1'b1;
        exu_pc          = 32'h8000_4000;
        exu_rd          = 5'd9;
        exu_rd_wen      = 1'b1;
        exu_is_load     = 1'b1;
        exu_load_funct3 = 3'b010;
        @(negedge clk);
        drive_idle();
        vectors++;
        if (pend_valid !== 1'b1 || pend_rd !== 5'd9) begin
            miscompares++;
            $display("FAIL rst_load_pending got pend=%b pend_rd=%0d want 1 9", pend_valid, pend_rd);
        end
        rst        = 1'b1;
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        rst        = 1'b0;
        lsu_rvalid = 1'b0;
        vectors++;
        if (exu_ready !== 1'b1 || pend_valid !== 1'b0 || pend_rd !== 5'd0
            || gpr_wen !== 1'b0 || commit_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_load_cleared got ready=%b pend=%b pend_rd=%0d wen=%b commit=%b want 1 0 0 0 0",
                     exu_ready, pend_valid, pend_rd, gpr_wen, commit_valid);
        end
        lsu_rvalid = 1'b1;
        @(negedge clk);
        lsu_rvalid = 1'b0;
        lsu_rdata  = 32'h0;
        vectors++;
        if (gpr_wen !== 1'b0 || commit_valid !== 1'b0 || exu_ready !== 1'b1 || gpr_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_load_late_rvalid got wen=%b commit=%b ready=%b wdata=%h want 0 0 1 00000000",
                     gpr_wen, commit_valid, exu_ready, gpr_wdata);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_alu_retire();
        test_back_to_back();
        test_load("lb",     3'b000, 2'd2, 5'd7,  32'h12A4_5678, 3, 32'hFFFF_FFA4);
        test_load("lbu",    3'b100, 2'd2, 5'd7,  32'h12A4_5678, 1, 32'h0000_00A4);
        test_load("lh",     3'b001, 2'd0, 5'd10, 32'h8001_F00F, 0, 32'hFFFF_F00F);
        test_load("lhu2",   3'b101, 2'd2, 5'd11, 32'h8001_F00F, 2, 32'h0000_8001);
        test_load("lhu3",   3'b101, 2'd3, 5'd12, 32'h8001_F00F, 0, 32'h0000_0080);
        test_load("lw",     3'b010, 2'd0, 5'd13, 32'h8001_F00F, 1, 32'h8001_F00F);
        test_load("f3_011", 3'b011, 2'd1, 5'd14, 32'h8001_F00F, 0, 32'h0080_01F0);
        test_load("lb_x0",  3'b000, 2'd0, 5'd0,  32'h0000_0081, 0, 32'hFFFF_FF81);
        test_x0_and_stray();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
